// File: rtl/estacionamiento_multi.sv
// Multi-lane parking occupancy controller: per-lane synchroniser, debouncer and
// direction FSM feeding one shared saturating occupancy counter.
//
// state  | meaning
// IDLE   | lane clear, waiting for a vehicle
// IN_A   | entering, outer sensor blocked
// IN_AB  | entering, both sensors blocked
// IN_B   | entering, only inner sensor blocked
// OUT_B  | leaving, inner sensor blocked
// OUT_AB | leaving, both sensors blocked
// OUT_A  | leaving, only outer sensor blocked
// ABORT  | illegal sequence seen, waiting for lane to clear
module estacionamiento_multi #(
    parameter int LANES      = 2,
    parameter int CAP        = 7,
    parameter int CNT_W      = 3,
    parameter int DEB_CYCLES = 10000,
    parameter int DEB_W      = 14
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [LANES-1:0] sens_a,
    input  logic [LANES-1:0] sens_b,
    input  logic             clr_err,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty,
    output logic [LANES-1:0] entry_pulse,
    output logic [LANES-1:0] exit_pulse,
    output logic [LANES-1:0] seq_err,
    output logic             ovf,
    output logic             udf
);

    typedef enum logic [2:0] {
        IDLE, IN_A, IN_AB, IN_B, OUT_B, OUT_AB, OUT_A, ABORT
    } state_t;

    localparam int PC_W = $clog2(LANES + 1);
    localparam int SW   = ((CNT_W > PC_W) ? CNT_W : PC_W) + 2;
    localparam logic signed [SW-1:0] CAP_S = SW'(CAP);

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        logic [1:0] raw;
        logic [1:0] sync_1;
        logic [1:0] sync_2;
        logic [1:0] deb;
        state_t     state;
        logic       ent_q;
        logic       ext_q;
        logic       err_q;

        assign raw = {sens_a[g], sens_b[g]};

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                sync_1 <= '0;
                sync_2 <= '0;
            end else begin
                sync_1 <= raw;
                sync_2 <= sync_1;
            end
        end

        for (genvar k = 0; k < 2; k++) begin : g_deb
            logic             deb_q;
            logic [DEB_W-1:0] deb_cnt;

            // Commit on the DEB_CYCLES-th consecutive cycle of disagreement.
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    deb_q   <= 1'b0;
                    deb_cnt <= '0;
                end else if (sync_2[k] == deb_q) begin
                    deb_cnt <= '0;
                end else if (deb_cnt == DEB_W'(DEB_CYCLES - 1)) begin
                    deb_q   <= sync_2[k];
                    deb_cnt <= '0;
                end else begin
                    deb_cnt <= deb_cnt + 1'b1;
                end
            end

            assign deb[k] = deb_q;
        end

        // deb[1] is the outer (A) sensor, deb[0] the inner (B) sensor.
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                state <= IDLE;
                ent_q <= 1'b0;
                ext_q <= 1'b0;
                err_q <= 1'b0;
            end else begin
                ent_q <= 1'b0;
                ext_q <= 1'b0;
                err_q <= 1'b0;
                case (state)
                    IDLE: begin
                        case (deb)
                            2'b10: state <= IN_A;
                            2'b01: state <= OUT_B;
                            2'b11: begin state <= ABORT; err_q <= 1'b1; end
                            default: state <= IDLE;
                        endcase
                    end
                    IN_A: begin
                        case (deb)
                            2'b11: state <= IN_AB;
                            2'b00: state <= IDLE;
                            2'b01: begin state <= ABORT; err_q <= 1'b1; end
                            default: state <= IN_A;
                        endcase
                    end
                    IN_AB: begin
                        case (deb)
                            2'b01: state <= IN_B;
                            2'b10: state <= IN_A;
                            2'b00: begin state <= ABORT; err_q <= 1'b1; end
                            default: state <= IN_AB;
                        endcase
                    end
                    IN_B: begin
                        case (deb)
                            2'b00: begin state <= IDLE; ent_q <= 1'b1; end
                            2'b11: state <= IN_AB;
                            2'b10: begin state <= ABORT; err_q <= 1'b1; end
                            default: state <= IN_B;
                        endcase
                    end
                    OUT_B: begin
                        case (deb)
                            2'b11: state <= OUT_AB;
                            2'b00: state <= IDLE;
                            2'b10: begin state <= ABORT; err_q <= 1'b1; end
                            default: state <= OUT_B;
                        endcase
                    end
                    OUT_AB: begin
                        case (deb)
                            2'b10: state <= OUT_A;
                            2'b01: state <= OUT_B;
                            2'b00: begin state <= ABORT; err_q <= 1'b1; end
                            default: state <= OUT_AB;
                        endcase
                    end
                    OUT_A: begin
                        case (deb)
                            2'b00: begin state <= IDLE; ext_q <= 1'b1; end
                            2'b11: state <= OUT_AB;
                            2'b01: begin state <= ABORT; err_q <= 1'b1; end
                            default: state <= OUT_A;
                        endcase
                    end
                    default: begin
                        if (deb == 2'b00) state <= IDLE;
                        else              state <= ABORT;
                    end
                endcase
            end
        end

        assign entry_pulse[g] = ent_q;
        assign exit_pulse[g]  = ext_q;
        assign seq_err[g]     = err_q;
    end

    logic        [SW-1:0]    n_ent;
    logic        [SW-1:0]    n_ext;
    logic signed [SW-1:0]    sum;
    logic        [CNT_W-1:0] count_nxt;
    logic                    set_ovf;
    logic                    set_udf;

    // Signed intermediate is wide enough that the net change can never wrap.
    always_comb begin
        n_ent = '0;
        n_ext = '0;
        for (int i = 0; i < LANES; i++) begin
            n_ent = n_ent + SW'(entry_pulse[i]);
            n_ext = n_ext + SW'(exit_pulse[i]);
        end
        sum     = SW'(count) + n_ent - n_ext;
        set_ovf = (sum > CAP_S);
        set_udf = sum[SW-1];
        if (set_ovf)      count_nxt = CNT_W'(CAP);
        else if (set_udf) count_nxt = '0;
        else              count_nxt = sum[CNT_W-1:0];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
            full  <= 1'b0;
            empty <= 1'b1;
            ovf   <= 1'b0;
            udf   <= 1'b0;
        end else begin
            count <= count_nxt;
            full  <= (count_nxt == CNT_W'(CAP));
            empty <= (count_nxt == '0);
            if (set_ovf)      ovf <= 1'b1;
            else if (clr_err) ovf <= 1'b0;
            if (set_udf)      udf <= 1'b1;
            else if (clr_err) udf <= 1'b0;
        end
    end

endmodule

// File: tb/tb_estacionamiento_multi.sv
// Directed bench for estacionamiento_multi with a short debounce window.
module tb_estacionamiento_multi;

    localparam int LANES = 2;
    localparam int CNT_W = 3;
    localparam int H     = 20;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic [LANES-1:0] sens_a = '0;
    logic [LANES-1:0] sens_b = '0;
    logic             clr_err = 1'b0;
    logic [CNT_W-1:0] count;
    logic             full, empty, ovf, udf;
    logic [LANES-1:0] entry_pulse, exit_pulse, seq_err;

    int errors = 0;
    int checks = 0;
    int ent_cnt [LANES];
    int ext_cnt [LANES];
    int err_cnt [LANES];
    int together = 0;
    int wide = 0;
    logic [LANES-1:0] prev_e = '0, prev_x = '0, prev_s = '0;

    estacionamiento_multi #(
        .LANES(LANES), .CAP(7), .CNT_W(CNT_W), .DEB_CYCLES(4), .DEB_W(3)
    ) dut (
        .clk(clk), .rst(rst), .sens_a(sens_a), .sens_b(sens_b), .clr_err(clr_err),
        .count(count), .full(full), .empty(empty), .entry_pulse(entry_pulse),
        .exit_pulse(exit_pulse), .seq_err(seq_err), .ovf(ovf), .udf(udf)
    );

    always #5 clk = ~clk;

    // Pulse monitor, sampled on the falling edge.
    always @(negedge clk) begin
        for (int i = 0; i < LANES; i++) begin
            if (entry_pulse[i]) ent_cnt[i]++;
            if (exit_pulse[i])  ext_cnt[i]++;
            if (seq_err[i])     err_cnt[i]++;
        end
        if (entry_pulse[0] && exit_pulse[1]) together++;
        if (|(entry_pulse & prev_e) || |(exit_pulse & prev_x) || |(seq_err & prev_s)) wide++;
        prev_e = entry_pulse;
        prev_x = exit_pulse;
        prev_s = seq_err;
    end

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic clear_mon();
        for (int i = 0; i < LANES; i++) begin
            ent_cnt[i] = 0;
            ext_cnt[i] = 0;
            err_cnt[i] = 0;
        end
        together = 0;
    endtask

    task automatic drive(input int lane, input bit a, input bit b, input int n);
        sens_a[lane] = a;
        sens_b[lane] = b;
        step(n);
    endtask

    task automatic entry(input int lane);
        drive(lane, 1, 0, H);
        drive(lane, 1, 1, H);
        drive(lane, 0, 1, H);
        drive(lane, 0, 0, H);
    endtask

    task automatic leave(input int lane);
        drive(lane, 0, 1, H);
        drive(lane, 1, 1, H);
        drive(lane, 1, 0, H);
        drive(lane, 0, 0, H);
    endtask

    task automatic do_reset();
        sens_a = '0;
        sens_b = '0;
        rst = 1'b0;
        step(3);
        rst = 1'b1;
        step(3);
        clear_mon();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit found;
        for (int i = 0; i < LANES; i++) begin
            ent_cnt[i] = 0; ext_cnt[i] = 0; err_cnt[i] = 0;
        end

        // 1: reset and idle
        step(2);
        chk("rst_count", count, 0);
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        rst = 1'b1;
        step(50);
        chk("idle_count", count, 0);
        chk("idle_empty", empty, 1);
        chk("idle_full", full, 0);
        chk("idle_ovf", ovf, 0);
        chk("idle_udf", udf, 0);
        chk("idle_pulses", ent_cnt[0] + ent_cnt[1] + ext_cnt[0] + ext_cnt[1] + err_cnt[0] + err_cnt[1], 0);

        // 2: one entry on lane 0, count follows the pulse by one cycle
        drive(0, 1, 0, H);
        drive(0, 1, 1, H);
        drive(0, 0, 1, H);
        sens_a[0] = 1'b0;
        sens_b[0] = 1'b0;
        found = 1'b0;
        for (int i = 0; i < H; i++) begin
            step(1);
            if (entry_pulse[0]) begin
                found = 1'b1;
                break;
            end
        end
        chk("t2_pulse_seen", found, 1);
        chk("t2_count_at_pulse", count, 0);
        step(1);
        chk("t2_count_after", count, 1);
        chk("t2_pulse_cleared", entry_pulse[0], 0);
        chk("t2_empty", empty, 0);
        step(H);
        chk("t2_entries", ent_cnt[0], 1);
        chk("t2_no_err", err_cnt[0], 0);

        // 3: short glitch on lane 0 A is filtered
        clear_mon();
        sens_a[0] = 1'b1;
        step(3);
        sens_a[0] = 1'b0;
        step(H);
        chk("t3_pulses", ent_cnt[0] + ext_cnt[0] + err_cnt[0], 0);
        chk("t3_count", count, 1);

        // 4: reach 3, then simultaneous entry lane 0 / exit lane 1
        entry(1);
        entry(0);
        chk("t4_count3", count, 3);
        clear_mon();
        sens_a = 2'b01; sens_b = 2'b10; step(H);
        sens_a = 2'b11; sens_b = 2'b11; step(H);
        sens_a = 2'b10; sens_b = 2'b01; step(H);
        sens_a = 2'b00; sens_b = 2'b00; step(H);
        chk("t4_together", together, 1);
        chk("t4_entry0", ent_cnt[0], 1);
        chk("t4_exit1", ext_cnt[1], 1);
        chk("t4_count", count, 3);

        // 5: fill to capacity, overflow, clear
        do_reset();
        for (int i = 0; i < 7; i++) entry(i % 2);
        chk("t5_count7", count, 7);
        chk("t5_full", full, 1);
        chk("t5_ovf_pre", ovf, 0);
        entry(0);
        chk("t5_count_sat", count, 7);
        chk("t5_ovf", ovf, 1);
        chk("t5_entries", ent_cnt[0] + ent_cnt[1], 8);
        clr_err = 1'b1;
        step(1);
        clr_err = 1'b0;
        step(1);
        chk("t5_ovf_clr", ovf, 0);
        chk("t5_full_hold", full, 1);

        // 6: illegal sequence, underflow, reset mid-sequence
        do_reset();
        drive(1, 1, 0, H);
        drive(1, 0, 1, H);
        chk("t6_seq_err", err_cnt[1], 1);
        chk("t6_count", count, 0);
        drive(1, 0, 0, H);
        leave(1);
        chk("t6_exit_pulse", ext_cnt[1], 1);
        chk("t6_udf_count", count, 0);
        chk("t6_udf", udf, 1);
        chk("t6_empty", empty, 1);
        entry(0);
        chk("t6_count1", count, 1);
        drive(0, 1, 0, H);
        drive(0, 1, 1, H);
        rst = 1'b0;
        #1;
        chk("t6_rst_count", count, 0);
        chk("t6_rst_empty", empty, 1);
        chk("t6_rst_udf", udf, 0);
        chk("t6_rst_pulses", {entry_pulse, exit_pulse, seq_err}, 0);
        sens_a = '0;
        sens_b = '0;
        step(3);
        rst = 1'b1;
        step(H);
        clear_mon();
        entry(0);
        chk("t6_post_entry", ent_cnt[0], 1);
        chk("t6_post_err", err_cnt[0], 0);
        chk("t6_post_count", count, 1);

        chk("pulse_width", wide, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/estacionamiento_multi.md
Name: estacionamiento_multi

Overview:
Multi-lane parking occupancy controller. It generalises the single-gate A/B sensor counter to LANES gates, each with its own sensor pair, debouncer and direction FSM. All lanes share one saturating occupancy counter with a configurable capacity, full/empty status and error reporting. It sits between the raw barrier sensors (buttons on the board) and the LED/status display.

Parameters:
LANES, 2, number of gates; each gate has one A (outer) and one B (inner) sensor.
CAP, 7, maximum occupancy; count saturates here.
CNT_W, 3, count width; must satisfy 2^CNT_W > CAP.
DEB_CYCLES, 10000, consecutive stable cycles required before a debounced input changes.
DEB_W, 14, debounce counter width; must satisfy 2^DEB_W > DEB_CYCLES.

Ports:
clk  in  1  system clock, all logic on the rising edge.
rst  in  1  asynchronous, active-low reset.
sens_a  in  LANES  raw outer sensor per lane, 1 = blocked, asynchronous to clk.
sens_b  in  LANES  raw inner sensor per lane, 1 = blocked, asynchronous to clk.
clr_err  in  1  synchronous clear of the sticky ovf/udf flags.
count  out  CNT_W  current occupancy.
full  out  1  count == CAP.
empty  out  1  count == 0.
entry_pulse  out  LANES  one-cycle pulse per completed entry, per lane.
exit_pulse  out  LANES  one-cycle pulse per completed exit, per lane.
seq_err  out  LANES  one-cycle pulse on an illegal sensor transition, per lane.
ovf  out  1  sticky: an entry was attempted while at CAP.
udf  out  1  sticky: an exit was attempted while at 0.

Behaviour:
- Reset (rst=0, asynchronous): count=0, empty=1, full=0, ovf=0, udf=0, all pulses 0, every FSM in IDLE, every debounced value 0, every debounce counter 0.
- Input conditioning: each raw input passes through a 2-flop synchroniser, then a debouncer.
  - The debounced value takes the synchronised value only after that value has differed from the debounced value for DEB_CYCLES consecutive cycles.
  - Any return to agreement resets the debounce counter to 0.
  - Latency from a raw edge to the debounced edge is 2+DEB_CYCLES cycles.
- Per-lane FSM, driven by the debounced pair {a,b}. States: IDLE, IN_A, IN_AB, IN_B, OUT_B, OUT_AB, OUT_A, ABORT.
  - IDLE: 10 -> IN_A; 01 -> OUT_B; 11 -> ABORT with seq_err; 00 stays.
  - IN_A: 11 -> IN_AB; 00 -> IDLE (backed out, no count); 01 -> ABORT with seq_err.
  - IN_AB: 01 -> IN_B; 10 -> IN_A; 00 -> ABORT with seq_err.
  - IN_B: 00 -> IDLE with entry_pulse; 11 -> IN_AB; 10 -> ABORT with seq_err.
  - Exit path mirrors the entry path with a and b swapped (OUT_B, OUT_AB, OUT_A); OUT_A + 00 -> IDLE with exit_pulse.
  - ABORT: stays until 00, then goes to IDLE. No pulse is issued on leaving ABORT.
- Pulses are registered and asserted in the cycle after the debounced input change that completes the sequence. Each pulse lasts exactly 1 cycle.
- Counter: on each edge, next = clamp(count + popcount(entry_pulse) - popcount(exit_pulse), 0, CAP).
  - count updates one cycle after the pulses.
  - Arithmetic uses CNT_W+2 bit signed intermediates, so there is no wrap-around.
  - Simultaneous entries and exits on different lanes net out; order is irrelevant.
  - If the unclamped result is > CAP, ovf is set; if it is < 0, udf is set.
- clr_err=1 clears ovf/udf on the next edge. A set condition in the same cycle as clr_err wins over the clear.
- full and empty are decoded from the count register and are glitch-free.
- Lanes are fully independent apart from the shared counter.

Test Plan:
1. Reset, then hold all inputs 0 for 50 cycles -> count=0, empty=1, full=0, ovf=udf=0, no pulses.
2. DEB_CYCLES=4. Lane0 drives A/B = 10,11,01,00, each held 20 cycles -> exactly one entry_pulse[0]; count=1 one cycle later; empty=0.
3. Lane0 raw glitch of 3 cycles on sens_a (< DEB_CYCLES) -> FSM stays IDLE, no pulses, count unchanged.
4. count=3. Lane0 entry and lane1 exit complete on the same cycle -> entry_pulse[0]=exit_pulse[1]=1 together; count stays 3.
5. Seven entries (count=7, full=1), then one more entry -> count stays 7 and ovf=1. Pulse clr_err -> ovf=0.
6. Lane1 drives 10 then 01 -> seq_err[1] one-cycle pulse, no count change; 00 returns the lane to IDLE. An exit at count=0 -> count=0, udf=1. Assert rst mid-sequence (lane0 in IN_AB) -> all outputs return to reset values immediately.
